// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, and a per-register
// busy scoreboard. Register 0 always reads zero and is never busy.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] read_data1,
   output logic [XLEN-1:0] read_data2,
   output logic            rs1_ready,
   output logic            rs2_ready,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] data_in,
   input  logic            reg_write,
   input  logic            alloc_valid,
   input  logic [AW-1:0]   alloc_rd,
   output logic            alloc_ok,
   output logic [NREG-1:0] busy_mask,
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;
   logic [AW:0]     r_busy_cnt;

   logic            w_wr;
   logic            w_alloc_ok;
   logic            w_inc;
   logic            w_dec;
   logic [NREG-1:0] w_busy_nxt;

   assign w_wr = reg_write & (rd != '0);

   // A write landing on the same register this cycle frees it for immediate re-allocation.
   assign w_alloc_ok = alloc_valid & (alloc_rd != '0) &
                       (~r_busy[alloc_rd] | (w_wr & (rd == alloc_rd)));

   assign w_inc = w_alloc_ok & ~r_busy[alloc_rd];
   assign w_dec = w_wr & r_busy[rd] & ~(w_alloc_ok & (alloc_rd == rd));

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr)
         w_busy_nxt[rd] = 1'b0;
      if (w_alloc_ok)
         w_busy_nxt[alloc_rd] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++)
            r_regs[i] <= '0;
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         if (w_wr)
            r_regs[rd] <= data_in;
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= r_busy_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
      end
   end

   always_comb begin
      read_data1 = '0;
      rs1_ready  = 1'b1;
      if (rs1 == '0) begin
         read_data1 = '0;
         rs1_ready  = 1'b1;
      end else if ((BYPASS != 0) && w_wr && (rd == rs1)) begin
         read_data1 = data_in;
         rs1_ready  = 1'b1;
      end else begin
         read_data1 = r_regs[rs1];
         rs1_ready  = ~r_busy[rs1];
      end
   end

   always_comb begin
      read_data2 = '0;
      rs2_ready  = 1'b1;
      if (rs2 == '0) begin
         read_data2 = '0;
         rs2_ready  = 1'b1;
      end else if ((BYPASS != 0) && w_wr && (rd == rs2)) begin
         read_data2 = data_in;
         rs2_ready  = 1'b1;
      end else begin
         read_data2 = r_regs[rs2];
         rs2_ready  = ~r_busy[rs2];
      end
   end

   assign alloc_ok   = w_alloc_ok;
   assign busy_mask  = r_busy;
   assign busy_count = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one bypassing and one non-bypassing instance share
// stimulus; an array-based model predicts both, a monitor compares away from the edge.
module tb_regfile_sb;

   logic        clk;
   logic        reset;
   logic [4:0]  rs1, rs2, rd, alloc_rd;
   logic [31:0] data_in;
   logic        reg_write, alloc_valid;

   logic [31:0] b1_rdata1, b1_rdata2, b0_rdata1, b0_rdata2;
   logic        b1_rdy1, b1_rdy2, b0_rdy1, b0_rdy2;
   logic        b1_aok, b0_aok;
   logic [31:0] b1_mask, b0_mask;
   logic [5:0]  b1_cnt, b0_cnt;

   regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_b1 (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
      .read_data1(b1_rdata1), .read_data2(b1_rdata2),
      .rs1_ready(b1_rdy1), .rs2_ready(b1_rdy2),
      .rd(rd), .data_in(data_in), .reg_write(reg_write),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ok(b1_aok),
      .busy_mask(b1_mask), .busy_count(b1_cnt)
   );

   regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_b0 (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
      .read_data1(b0_rdata1), .read_data2(b0_rdata2),
      .rs1_ready(b0_rdy1), .rs2_ready(b0_rdy2),
      .rd(rd), .data_in(data_in), .reg_write(reg_write),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ok(b0_aok),
      .busy_mask(b0_mask), .busy_count(b0_cnt)
   );

   typedef struct {
      logic [31:0] b1_d1, b1_d2, b0_d1, b0_d2;
      logic        b1_r1, b1_r2, b0_r1, b0_r2;
      logic        aok;
      logic [31:0] mask;
      logic [5:0]  cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("b1_read_data1", b1_rdata1, e.b1_d1);
         chk("b1_read_data2", b1_rdata2, e.b1_d2);
         chk("b1_rs1_ready", {31'd0, b1_rdy1}, {31'd0, e.b1_r1});
         chk("b1_rs2_ready", {31'd0, b1_rdy2}, {31'd0, e.b1_r2});
         chk("b0_read_data1", b0_rdata1, e.b0_d1);
         chk("b0_read_data2", b0_rdata2, e.b0_d2);
         chk("b0_rs1_ready", {31'd0, b0_rdy1}, {31'd0, e.b0_r1});
         chk("b0_rs2_ready", {31'd0, b0_rdy2}, {31'd0, e.b0_r2});
         chk("b1_alloc_ok", {31'd0, b1_aok}, {31'd0, e.aok});
         chk("b0_alloc_ok", {31'd0, b0_aok}, {31'd0, e.aok});
         chk("b1_busy_mask", b1_mask, e.mask);
         chk("b0_busy_mask", b0_mask, e.mask);
         chk("b1_busy_count", {26'd0, b1_cnt}, {26'd0, e.cnt});
         chk("b0_busy_count", {26'd0, b0_cnt}, {26'd0, e.cnt});
      end
   end

   function automatic void model_read(input bit byp, input logic [4:0] rs,
                                      output logic [31:0] d, output logic r);
      if (rs == 0) begin
         d = 0; r = 1;
      end else if (byp && reg_write && rd != 0 && rd == rs) begin
         d = data_in; r = 1;
      end else begin
         d = m_regs[rs]; r = !m_busy[rs];
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 0;
         m_busy[i] = 0;
      end
   endfunction

   // mode: 0 normal, 1 reset held across the edge, 2 reset pulse released before the edge
   task automatic cycle(input bit w, input logic [4:0] wrd, input logic [31:0] wd,
                        input bit av, input logic [4:0] ard,
                        input logic [4:0] a1, input logic [4:0] a2, input int mode);
      exp_t e;
      bit   aok;
      @(negedge clk);
      reg_write = w; rd = wrd; data_in = wd;
      alloc_valid = av; alloc_rd = ard; rs1 = a1; rs2 = a2;
      reset = (mode != 0);
      if (mode != 0) model_clear();
      #1;
      aok = av && ard != 0 && (!m_busy[ard] || (w && wrd == ard));
      model_read(1'b1, a1, e.b1_d1, e.b1_r1);
      model_read(1'b1, a2, e.b1_d2, e.b1_r2);
      model_read(1'b0, a1, e.b0_d1, e.b0_r1);
      model_read(1'b0, a2, e.b0_d2, e.b0_r2);
      e.aok = aok;
      e.mask = 0;
      e.cnt  = 0;
      for (int i = 0; i < 32; i++) begin
         e.mask[i] = m_busy[i];
         e.cnt     = e.cnt + {5'd0, m_busy[i]};
      end
      sb_q.push_back(e);
      if (mode != 1) begin
         if (w && wrd != 0) begin
            m_regs[wrd] = wd;
            m_busy[wrd] = 0;
         end
         if (aok) m_busy[ard] = 1;
      end
      if (mode == 2) begin
         #3;
         reset = 1'b0;
      end
   endtask

   initial begin
      int wait_cycles;
      reset = 1'b1; reg_write = 0; rd = 0; data_in = 0;
      alloc_valid = 0; alloc_rd = 0; rs1 = 0; rs2 = 0;
      model_clear();

      // reset held across an edge with a write and alloc that must be discarded
      cycle(1, 5'd4, 32'hDEAD_BEEF, 1, 5'd4, 5'd4, 5'd0, 1);
      cycle(0, 0, 0, 0, 0, 5'd4, 5'd4, 0);

      cycle(1, 5'd1, 32'd15, 0, 0, 5'd1, 5'd0, 0);
      cycle(1, 5'd11, 32'd12, 0, 0, 5'd1, 5'd11, 0);
      cycle(1, 5'd12, 32'd10, 0, 0, 5'd11, 5'd12, 0);
      cycle(1, 5'd13, 32'd9, 0, 0, 5'd11, 5'd12, 0);

      cycle(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd0, 5'd0, 0);
      cycle(0, 0, 0, 0, 0, 5'd0, 5'd13, 0);

      cycle(0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 0);
      cycle(0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 0);
      cycle(1, 5'd5, 32'h1234, 0, 0, 5'd5, 5'd5, 0);
      cycle(0, 0, 0, 0, 0, 5'd5, 5'd5, 0);

      cycle(0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0);
      cycle(1, 5'd7, 32'h7777, 1, 5'd7, 5'd7, 5'd7, 0);
      cycle(0, 0, 0, 0, 0, 5'd7, 5'd7, 0);

      cycle(1, 5'd3, 32'hA5, 0, 0, 5'd3, 5'd3, 0);
      cycle(0, 0, 0, 0, 0, 5'd3, 5'd3, 0);

      // write to a register that is not busy, then write+alloc on a free register
      cycle(1, 5'd9, 32'h99, 0, 0, 5'd9, 5'd0, 0);
      cycle(1, 5'd10, 32'hAA, 1, 5'd10, 5'd10, 5'd9, 0);
      cycle(0, 0, 0, 0, 0, 5'd10, 5'd9, 0);

      cycle(1, 5'd2, 32'h55, 0, 0, 5'd2, 5'd0, 0);
      cycle(0, 0, 0, 1, 5'd2, 5'd2, 5'd2, 0);
      cycle(0, 0, 0, 0, 0, 5'd2, 5'd2, 0);
      cycle(0, 0, 0, 0, 0, 5'd2, 5'd2, 2);
      cycle(0, 0, 0, 0, 0, 5'd2, 5'd1, 0);

      for (int n = 0; n < 600; n++) begin
         int rmode;
         rmode = ($urandom_range(0, 99) == 0) ? int'($urandom_range(1, 2)) : 0;
         cycle($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rmode);
      end
      // fill nearly every register to exercise the upper end of busy_count
      for (int n = 1; n < 32; n++)
         cycle(0, 0, 0, 1, 5'(n), 5'(n), 5'(n - 1), 0);
      for (int n = 0; n < 40; n++)
         cycle($urandom_range(0, 1), 5'($urandom), $urandom,
               $urandom_range(0, 1), 5'($urandom),
               5'($urandom), 5'($urandom), 0);
      cycle(0, 0, 0, 0, 0, 5'd31, 5'd30, 0);

      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0 pending entries", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=%0t expected=finish before limit", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register busy scoreboard and optional write-to-read bypass, for the in-order pipeline datapath. It provides two combinational read ports and one synchronous write port, with register 0 hardwired to zero. A destination-allocation port marks registers as pending, so decode can stall on RAW hazards without a separate hazard unit. It is the drop-in successor to the fixed 32×32 two-read/one-write register file.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, ≥ 2; address width AW = log2(NREG) (localparam)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports (reset is asynchronous and active-high):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rs1  in  AW  read port 1 address
- rs2  in  AW  read port 2 address
- read_data1  out  XLEN  read port 1 data (combinational)
- read_data2  out  XLEN  read port 2 data (combinational)
- rs1_ready  out  1  read port 1 value is architecturally valid
- rs2_ready  out  1  read port 2 value is architecturally valid
- rd  in  AW  write address
- data_in  in  XLEN  write data
- reg_write  in  1  write enable
- alloc_valid  in  1  request to mark alloc_rd pending
- alloc_rd  in  AW  register to allocate
- alloc_ok  out  1  allocation accepted this cycle (combinational)
- busy_mask  out  NREG  registered busy bit per register; bit 0 always 0
- busy_count  out  AW+1  registered count of set busy bits

## Operation
- Storage: regs[1..NREG-1] are XLEN-bit flops. Register 0 is not stored, always reads 0, and is never busy.
- Write: at a rising edge with reg_write=1 and rd≠0, regs[rd] <= data_in and busy[rd] is cleared. A write with rd=0 is ignored entirely.
- Write to a non-busy register is legal: data is written and busy is unchanged (0).
- Allocate: alloc_ok = alloc_valid & (alloc_rd≠0) & (~busy[alloc_rd] | (reg_write & rd==alloc_rd)). At the edge, alloc_ok=1 sets busy[alloc_rd].
- Allocation to a busy register without a matching write that cycle is refused: alloc_ok=0 and no state change. The requester must hold its request.
- Same-cycle write and alloc to the same register: data is written AND busy ends at 1 (alloc wins over clear).
- Read, for each port p with address rsp:
  - rsp=0 → data 0, ready 1.
  - BYPASS=1 and reg_write & rd==rsp & rd≠0 → data = data_in, ready = 1.
  - Otherwise → data = regs[rsp], ready = ~busy[rsp].
- busy_count tracks popcount(busy_mask) incrementally:
  - +1 on accepted alloc of a register that ends busy and was not busy before.
  - −1 on a write clearing a busy bit with no re-alloc.
  - Net 0 when the same register is written and re-allocated in one cycle.
  - Never exceeds NREG−1.

## Timing
- Reset: asserting reset immediately clears all regs, busy_mask = 0, and busy_count = 0, independent of clk. Consequently read_data1/2 = 0, rs1_ready = rs2_ready = 1, and alloc_ok = alloc_valid & (alloc_rd≠0).
- Reset asserted mid-operation discards any write or alloc presented in that cycle. The first update happens at the first rising edge after deassertion.
- Write latency: with BYPASS=0, data appears on a read port the cycle after the write edge. With BYPASS=1, it appears in the same cycle (combinational).
- Busy latency: busy set by alloc is visible on busy_mask and ready outputs the cycle after the accepting edge. A clear by write is visible the next cycle, or the same cycle through bypass when BYPASS=1.
- No handshake on the write port: every reg_write cycle is accepted. The alloc port is accepted iff alloc_ok=1 in that cycle.
- Both read ports may address the same register, and both may match the write port simultaneously. The bypass applies to each port independently.
- No combinational path from alloc_* to read_data*. A combinational path exists from rd/data_in/reg_write to read_data*/rsN_ready only when BYPASS=1.

## Test plan
- Reset then basic write/read (BYPASS=1): write 15→r1, 12→r11, 10→r12 on successive edges. Then rs1=11, rs2=12 with a concurrent write 9→r13 → read_data1=12, read_data2=10, both ready=1.
- Register 0: reg_write=1, rd=0, data_in=0xFFFF_FFFF; then rs1=0 → read_data1=0, rs1_ready=1. alloc_rd=0 → alloc_ok=0, busy_count stays 0.
- Scoreboard: alloc r5 → next cycle busy_mask[5]=1, busy_count=1, rs1=5 gives rs1_ready=0. A second alloc of r5 → alloc_ok=0. Write 0x1234 to r5 → same cycle rs1_ready=1 and read_data1=0x1234 (bypass); next cycle busy_count=0.
- Simultaneous write+alloc to r7 (r7 busy): alloc_ok=1, r7 = written value, busy_mask[7] stays 1, busy_count unchanged.
- BYPASS=0 instance: write 0xA5 to r3 with rs2=3 → read_data2 shows old value (0) that cycle and 0xA5 the next.
- Async reset mid-operation: with r2 busy and data held, pulse reset between clock edges → outputs clear without a clock edge, busy_count=0, and r2 reads 0.
